// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated TX FIFO; frames are sent back-to-back while words are queued.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (PARITY_ODD selects odd parity).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf,
    output logic                          tx,
    output logic                          busy
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DW_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] SB_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   full_q, full_d;
    logic                   ovf_q, ovf_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;

    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [DATA_WIDTH-1:0]  shifted;
    logic                   push;
    logic                   pop;
    logic                   baud_tick;

    assign push      = wr_en && !full_q;
    assign baud_tick = (baud_q == DIV_LAST);
    // Word under transmission is held still; the current bit is selected by index.
    assign shifted   = shift_q >> bit_q;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
    assign parity_bit = (^shift_q) ^ (PARITY_ODD != 0);
`endif

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        pop      = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_q == DW_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (bit_q == SB_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when more words wait.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_FULL);
        ovf_d  = wr_en && full_q;
        busy_d = (state_q != IDLE) || (count_q != '0);

        // Line level follows the current state one clock later, from a flop.
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shifted[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_bit;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // Storage and the registered read into the frame register share one RAM-style process.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
        if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
        end
    end

    assign full       = full_q;
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign tx         = tx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 and 2 stop bits) checked against a frame-level model.
module tb_uart_tx_fifo;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LOGSZ = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en1, wr_en2;
    logic [7:0] wr_data1, wr_data2;
    logic       full1, full2, ovf1, ovf2, tx1, tx2, busy1, busy2;
    logic [2:0] count1, count2;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8), .STOP_BITS(1),
                   .FIFO_DEPTH(4), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .full(full1),
        .fifo_count(count1), .ovf(ovf1), .tx(tx1), .busy(busy1));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8), .STOP_BITS(2),
                   .FIFO_DEPTH(4), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2), .full(full2),
        .fifo_count(count2), .ovf(ovf2), .tx(tx2), .busy(busy2));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic tx1_log [LOGSZ];
    logic tx2_log [LOGSZ];
    logic busy1_log [LOGSZ];
    logic busy2_log [LOGSZ];

    logic [7:0] exp_w [16];
    int         exp_n;
    int         cnt_obs [8];
    logic       full_obs [8];
    logic       ovf_obs [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Log the line value present after edge number cyc.
    always @(negedge clk) begin
        if (cyc < LOGSZ) begin
            tx1_log[cyc]   <= tx1;
            tx2_log[cyc]   <= tx2;
            busy1_log[cyc] <= busy1;
            busy2_log[cyc] <= busy2;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level j clocks after the first start bit of a burst of exp_n words.
    function automatic logic model_tx(input int j, input int sb, input bit podd);
        int len;
        int f;
        int o;
        len = (1 + 8 + PBITS + sb) * DIV;
        if (j < 0) return 1'b1;
        f = j / len;
        if (f >= exp_n) return 1'b1;
        o = (j % len) / DIV;
        if (o == 0) return 1'b0;
        if (o <= 8) return exp_w[f][o-1];
        if (PBITS == 1 && o == 9) return podd ? ~^exp_w[f] : ^exp_w[f];
        return 1'b1;
    endfunction

    function automatic logic log_tx(input bit which, input int idx);
        return which ? tx2_log[idx] : tx1_log[idx];
    endfunction

    function automatic logic log_busy(input bit which, input int idx);
        return which ? busy2_log[idx] : busy1_log[idx];
    endfunction

    task automatic write_burst(input bit which, input int k, output int n0);
        n0 = 0;
        for (int i = 0; i <= k; i++) begin
            if (which) begin
                wr_en2   = (i < k);
                wr_data2 = (i < k) ? exp_w[i] : 8'($urandom);
            end else begin
                wr_en1   = (i < k);
                wr_data1 = (i < k) ? exp_w[i] : 8'($urandom);
            end
            @(posedge clk);
            #1;
            if (i == 0) n0 = cyc;
            cnt_obs[i]  = which ? int'(count2) : int'(count1);
            full_obs[i] = which ? full2 : full1;
            ovf_obs[i]  = which ? ovf2 : ovf1;
        end
        wr_en1 = 1'b0;
        wr_en2 = 1'b0;
    endtask

    // Burst of k writes on consecutive clocks into an idle transmitter, then check the line.
    task automatic run_burst(input bit which, input int k, input int sb, input bit podd,
                             input string tag, output int s);
        int n0, total, acc, ce, act_i;
        logic ae, ab;
        exp_n = (k > 5) ? 5 : k;
        write_burst(which, k, n0);
        for (int i = 0; i <= k; i++) begin
            // Only the first word has left the FIFO during the burst, so at most 5 are accepted.
            acc = (i + 1 < k) ? i + 1 : k;
            if (acc > 5) acc = 5;
            ce = acc - ((i >= 1) ? 1 : 0);
            act_i = cnt_obs[i];
            checks++;
            if (act_i !== ce) begin
                errors++;
                $display("FAIL %s count@%0d: got %0d want %0d", tag, i, act_i, ce);
            end
            checks++;
            if (full_obs[i] !== (ce == 4)) begin
                errors++;
                $display("FAIL %s full@%0d: got %b want %b", tag, i, full_obs[i], ce == 4);
            end
            checks++;
            if (ovf_obs[i] !== (i < k && i >= 5)) begin
                errors++;
                $display("FAIL %s ovf@%0d: got %b want %b", tag, i, ovf_obs[i], (i < k && i >= 5));
            end
        end
        s = n0 + 2;
        total = exp_n * (1 + 8 + PBITS + sb) * DIV;
        while (cyc < s + total + 4) @(posedge clk);
        #1;
        for (int j = -1; j < total + 3; j++) begin
            ae = model_tx(j, sb, podd);
            checks++;
            if (log_tx(which, s + j) !== ae) begin
                errors++;
                $display("FAIL %s tx@%0d: got %b want %b", tag, j, log_tx(which, s + j), ae);
            end
        end
        ab = log_busy(which, s + total - 1);
        checks++;
        if (ab !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_last_stop: got %b want 1", tag, ab);
        end
        ab = log_busy(which, s + total);
        checks++;
        if (ab !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after: got %b want 0", tag, ab);
        end
        $display("burst %s dut%0d k=%0d first=%h line checked from cycle %0d", tag, which + 1, k, exp_w[0], s);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        wr_en1 = 1'b0; wr_en2 = 1'b0; wr_data1 = '0; wr_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx1 !== 1'b1)     begin errors++; $display("FAIL reset tx1: got %b want 1", tx1); end
        checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL reset busy1: got %b want 0", busy1); end
        checks++; if (full1 !== 1'b0)   begin errors++; $display("FAIL reset full1: got %b want 0", full1); end
        checks++; if (ovf1 !== 1'b0)    begin errors++; $display("FAIL reset ovf1: got %b want 0", ovf1); end
        checks++; if (count1 !== 3'd0)  begin errors++; $display("FAIL reset count1: got %0d want 0", count1); end
        checks++; if (tx2 !== 1'b1)     begin errors++; $display("FAIL reset tx2: got %b want 1", tx2); end
        checks++; if (busy2 !== 1'b0)   begin errors++; $display("FAIL reset busy2: got %b want 0", busy2); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL post_reset idle: got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_single;
        int s;
        exp_w[0] = 8'hA5;
        run_burst(1'b0, 1, 1, 1'b1, "single_a5", s);
    endtask

    task automatic test_back_to_back;
        int s;
        exp_w[0] = 8'hA5;
        exp_w[1] = 8'h3C;
        run_burst(1'b0, 2, 1, 1'b1, "b2b", s);
    endtask

    task automatic test_overflow;
        int s;
        for (int i = 0; i < 6; i++) exp_w[i] = 8'(i + 1);
        run_burst(1'b0, 6, 1, 1'b1, "overflow", s);
    endtask

    task automatic test_stop2;
        int s, l2;
        exp_w[0] = 8'hFF;
        exp_w[1] = 8'h3C;
        run_burst(1'b1, 2, 2, 1'b0, "stop2", s);
        l2 = (1 + 8 + PBITS + 2) * DIV;
        checks++;
        if (tx2_log[s + l2] !== 1'b0 || tx2_log[s + l2 - 1] !== 1'b1) begin
            errors++;
            $display("FAIL stop2 second_start: got %b%b want 10", tx2_log[s + l2 - 1], tx2_log[s + l2]);
        end
    endtask

    task automatic test_random;
        int s, k;
        bit which;
        for (int r = 0; r < 10; r++) begin
            which = 1'($urandom_range(0, 1));
            k = int'($urandom_range(1, 6));
            for (int i = 0; i < k; i++) exp_w[i] = 8'($urandom);
            run_burst(which, k, which ? 2 : 1, which ? 1'b0 : 1'b1, "random", s);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        int s;
        exp_w[0] = 8'h07;
        exp_w[1] = 8'h03;
        run_burst(1'b0, 2, 1, 1'b1, "parity", s);
        checks++;
        if (tx1_log[s + 95] !== 1'b0) begin
            errors++; $display("FAIL parity_07: got %b want 0", tx1_log[s + 95]);
        end
        checks++;
        if (tx1_log[s + 110 + 95] !== 1'b1) begin
            errors++; $display("FAIL parity_03: got %b want 1", tx1_log[s + 205]);
        end
    endtask
`endif

    task automatic test_mid_frame_reset;
        int n0, s, r, bad;
        exp_w[0] = 8'h3C;
        exp_w[1] = 8'hA5;
        exp_w[2] = 8'h5A;
        write_burst(1'b0, 3, n0);
        s = n0 + 2;
        while (cyc < s + 25) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (tx1 !== 1'b1)    begin errors++; $display("FAIL midreset tx: got %b want 1", tx1); end
        checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL midreset busy: got %b want 0", busy1); end
        checks++; if (count1 !== 3'd0) begin errors++; $display("FAIL midreset count: got %0d want 0", count1); end
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        r = cyc;
        repeat (300) @(posedge clk);
        #1;
        bad = 0;
        for (int j = r + 1; j < r + 300; j++) begin
            if (tx1_log[j] !== 1'b1 || busy1_log[j] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midreset idle_after: got %0d active cycles want 0", bad);
        end
        $display("mid-frame reset: abort and idle line checked");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_stop2();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
